texture_bilinear_filter: RTL and testbench

Downstream stage of the texture buffer in the TMU. It consumes the four neighbouring RGBA8888 texels (00, 01, 10, 11) that the buffer returns, together with the 8-bit sub-texel fractions. It produces one filtered RGBA8888 texel per cycle, using either bilinear interpolation or nearest-texel selection. It is a fixed-latency, stallable pipeline with a valid flag and an opaque sideband tag carried alongside each texel.

---
 rtl/tmu_pkg.sv | 28 ++
 rtl/texture_bilinear_filter_if.sv | 31 +++
 rtl/texel_lerp.sv | 23 ++
 rtl/texture_bilinear_filter.sv | 93 +++++++++
 tb/tb_texture_bilinear_filter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tmu_pkg.sv
// Shared TMU definitions: texel layout, fraction width and nearest-texel selector encoding.
package tmu_pkg;

  localparam int unsigned PIXEL_WIDTH     = 32;
  localparam int unsigned SUB_PIXEL_WIDTH = 8;
  localparam int unsigned FRAC_WIDTH      = 8;
  localparam int unsigned NUM_CHANNELS    = PIXEL_WIDTH / SUB_PIXEL_WIDTH;
  // a*(256-f) + b*f peaks at 65280, so one bit beyond 16 covers the 256-f term
  localparam int unsigned LERP_WIDTH      = 2 * SUB_PIXEL_WIDTH + 1;

  localparam int unsigned CHAN_A = 0;
  localparam int unsigned CHAN_B = 8;
  localparam int unsigned CHAN_G = 16;
  localparam int unsigned CHAN_R = 24;

  // Encoded as {fracT msb, fracS msb}
  typedef enum logic [1:0] {
    Sel00 = 2'b00,
    Sel01 = 2'b01,
    Sel10 = 2'b10,
    Sel11 = 2'b11
  } near_sel_e;

  function automatic int unsigned chanLsb(input int unsigned ch);
    return ch * SUB_PIXEL_WIDTH;
  endfunction

endpackage

// File: rtl/texture_bilinear_filter_if.sv
// Beat-level bus between the texture buffer, the bilinear filter and its consumer.
interface texture_bilinear_filter_if #(
  parameter int unsigned PIXEL_WIDTH = tmu_pkg::PIXEL_WIDTH,
  parameter int unsigned FRAC_WIDTH  = tmu_pkg::FRAC_WIDTH,
  parameter int unsigned TAG_WIDTH   = 16
);

  logic                   confEnableFilter;
  logic                   s_valid;
  logic [TAG_WIDTH-1:0]   s_tag;
  logic [PIXEL_WIDTH-1:0] texel00;
  logic [PIXEL_WIDTH-1:0] texel01;
  logic [PIXEL_WIDTH-1:0] texel10;
  logic [PIXEL_WIDTH-1:0] texel11;
  logic [FRAC_WIDTH-1:0]  fracS;
  logic [FRAC_WIDTH-1:0]  fracT;
  logic                   m_valid;
  logic [TAG_WIDTH-1:0]   m_tag;
  logic [PIXEL_WIDTH-1:0] m_texel;

  modport master (
    output confEnableFilter, s_valid, s_tag, texel00, texel01, texel10, texel11, fracS, fracT,
    input  m_valid, m_tag, m_texel
  );

  modport slave (
    input  confEnableFilter, s_valid, s_tag, texel00, texel01, texel10, texel11, fracS, fracT,
    output m_valid, m_tag, m_texel
  );

endinterface

// File: rtl/texel_lerp.sv
// Single-channel linear interpolation: (a*(256-f) + b*f) >> 8, floored.
module texel_lerp
  import tmu_pkg::*;
(
  input  logic [SUB_PIXEL_WIDTH-1:0] a_i,
  input  logic [SUB_PIXEL_WIDTH-1:0] b_i,
  input  logic [FRAC_WIDTH-1:0]      f_i,
  output logic [SUB_PIXEL_WIDTH-1:0] res_o
);

  logic [LERP_WIDTH-1:0] sum;
  logic [SUB_PIXEL_WIDTH:0] unused_sum;

  always_comb begin
    sum = LERP_WIDTH'(a_i) * (LERP_WIDTH'(256) - LERP_WIDTH'(f_i))
        + LERP_WIDTH'(b_i) * LERP_WIDTH'(f_i);
  end

  // Top bit is always zero (max 65280); low byte is the discarded fraction
  assign res_o      = sum[2*SUB_PIXEL_WIDTH-1:SUB_PIXEL_WIDTH];
  assign unused_sum = {sum[LERP_WIDTH-1], sum[SUB_PIXEL_WIDTH-1:0]};

endmodule

// File: rtl/texture_bilinear_filter.sv
// Three-stage, ce-stallable RGBA8888 bilinear / nearest texel filter with tag passthrough.
module texture_bilinear_filter #(
  parameter int unsigned PIXEL_WIDTH = tmu_pkg::PIXEL_WIDTH,
  parameter int unsigned FRAC_WIDTH  = tmu_pkg::FRAC_WIDTH,
  parameter int unsigned TAG_WIDTH   = 16
) (
  input logic                      aclk,
  input logic                      resetn,
  input logic                      ce,
  texture_bilinear_filter_if.slave bus
);

  import tmu_pkg::*;

  logic [PIXEL_WIDTH-1:0] lerpTop, lerpBot, lerpRes, nearTexel;
  logic [PIXEL_WIDTH-1:0] top_d, res_d;
  logic [PIXEL_WIDTH-1:0] top_q, bot_q, res_q, out_q;
  logic [FRAC_WIDTH-1:0]  fracT_q;
  logic                   filter_q;
  logic [TAG_WIDTH-1:0]   tag1_q, tag2_q, tag3_q;
  logic [2:0]             valid_q;
  near_sel_e              nearSel;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : gen_chan
    localparam int unsigned Lo = chanLsb(c);

    texel_lerp u_lerp_top (
      .a_i   (bus.texel00[Lo +: SUB_PIXEL_WIDTH]),
      .b_i   (bus.texel01[Lo +: SUB_PIXEL_WIDTH]),
      .f_i   (bus.fracS),
      .res_o (lerpTop[Lo +: SUB_PIXEL_WIDTH])
    );

    texel_lerp u_lerp_bot (
      .a_i   (bus.texel10[Lo +: SUB_PIXEL_WIDTH]),
      .b_i   (bus.texel11[Lo +: SUB_PIXEL_WIDTH]),
      .f_i   (bus.fracS),
      .res_o (lerpBot[Lo +: SUB_PIXEL_WIDTH])
    );

    texel_lerp u_lerp_vert (
      .a_i   (top_q[Lo +: SUB_PIXEL_WIDTH]),
      .b_i   (bot_q[Lo +: SUB_PIXEL_WIDTH]),
      .f_i   (fracT_q),
      .res_o (lerpRes[Lo +: SUB_PIXEL_WIDTH])
    );
  end

  // Nearest mode rides in the top slot so stage 2 only needs a bypass mux
  always_comb begin
    nearSel   = near_sel_e'({bus.fracT[FRAC_WIDTH-1], bus.fracS[FRAC_WIDTH-1]});
    nearTexel = bus.texel00;
    unique case (nearSel)
      Sel00: nearTexel = bus.texel00;
      Sel01: nearTexel = bus.texel01;
      Sel10: nearTexel = bus.texel10;
      Sel11: nearTexel = bus.texel11;
    endcase
    top_d = bus.confEnableFilter ? lerpTop : nearTexel;
    res_d = filter_q ? lerpRes : top_q;
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      valid_q  <= '0;
      top_q    <= '0;
      bot_q    <= '0;
      fracT_q  <= '0;
      filter_q <= 1'b0;
      tag1_q   <= '0;
      res_q    <= '0;
      tag2_q   <= '0;
      out_q    <= '0;
      tag3_q   <= '0;
    end else if (ce) begin
      valid_q  <= {valid_q[1:0], bus.s_valid};
      top_q    <= top_d;
      bot_q    <= lerpBot;
      fracT_q  <= bus.fracT;
      filter_q <= bus.confEnableFilter;
      tag1_q   <= bus.s_tag;
      res_q    <= res_d;
      tag2_q   <= tag1_q;
      out_q    <= res_q;
      tag3_q   <= tag2_q;
    end
  end

  assign bus.m_valid = valid_q[2];
  assign bus.m_tag   = tag3_q;
  assign bus.m_texel = out_q;

endmodule

// File: tb/tb_texture_bilinear_filter.sv
// Scoreboard bench: stimulus pushes expected beats, an independent monitor checks every edge.
module tb_texture_bilinear_filter;

  typedef struct {
    logic [15:0] tag;
    logic [31:0] texel;
    int          due;
  } exp_t;

  logic aclk;
  logic resetn;
  logic ce;

  exp_t        sb[$];
  int          ceEdges;
  int          errors;
  int          checks;
  logic        lastExpValid;
  logic [31:0] lastExpTexel;
  logic [15:0] lastExpTag;

  texture_bilinear_filter_if #(.PIXEL_WIDTH(32), .FRAC_WIDTH(8), .TAG_WIDTH(16)) bus ();

  texture_bilinear_filter #(.PIXEL_WIDTH(32), .FRAC_WIDTH(8), .TAG_WIDTH(16)) dut (
    .aclk   (aclk),
    .resetn (resetn),
    .ce     (ce),
    .bus    (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Straight from the interpolation formula, used for the randomised stream
  function automatic logic [31:0] refFilter(input logic filt, input logic [31:0] t00,
                                            input logic [31:0] t01, input logic [31:0] t10,
                                            input logic [31:0] t11, input logic [7:0] fs,
                                            input logic [7:0] ft);
    logic [31:0] r;
    int a, b, c, d, top, bot;
    if (!filt) begin
      if (ft[7]) return fs[7] ? t11 : t10;
      return fs[7] ? t01 : t00;
    end
    r = '0;
    for (int ch = 0; ch < 4; ch++) begin
      a   = int'(t00[ch*8 +: 8]);
      b   = int'(t01[ch*8 +: 8]);
      c   = int'(t10[ch*8 +: 8]);
      d   = int'(t11[ch*8 +: 8]);
      top = (a * (256 - int'(fs)) + b * int'(fs)) / 256;
      bot = (c * (256 - int'(fs)) + d * int'(fs)) / 256;
      r[ch*8 +: 8] = 8'((top * (256 - int'(ft)) + bot * int'(ft)) / 256);
    end
    return r;
  endfunction

  task automatic sendBeat(input logic filt, input logic [15:0] tag, input logic [31:0] t00,
                          input logic [31:0] t01, input logic [31:0] t10, input logic [31:0] t11,
                          input logic [7:0] fs, input logic [7:0] ft, input logic [31:0] expTexel);
    exp_t item;
    @(negedge aclk);
    ce                   = 1'b1;
    bus.s_valid          = 1'b1;
    bus.confEnableFilter = filt;
    bus.s_tag            = tag;
    bus.texel00          = t00;
    bus.texel01          = t01;
    bus.texel10          = t10;
    bus.texel11          = t11;
    bus.fracS            = fs;
    bus.fracT            = ft;
    item.tag   = tag;
    item.texel = expTexel;
    item.due   = ceEdges + 3;
    sb.push_back(item);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge aclk);
      ce          = 1'b1;
      bus.s_valid = 1'b0;
    end
  endtask

  // Garbage beats offered while stalled must be ignored
  task automatic stall(input int n);
    repeat (n) begin
      @(negedge aclk);
      ce          = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_tag   = 16'hDEAD;
      bus.texel00 = $urandom;
      bus.fracS   = 8'h00;
      bus.fracT   = 8'h00;
    end
  endtask

  // Monitor: compares every clock edge against the scoreboard
  initial begin
    logic ceAtEdge, rstAtEdge, expValid;
    exp_t item;
    forever begin
      @(posedge aclk);
      ceAtEdge  = ce;
      rstAtEdge = resetn;
      #1;
      if (rstAtEdge && resetn) begin
        if (ceAtEdge) begin
          ceEdges++;
          expValid = (sb.size() > 0) && (sb[0].due == ceEdges);
          check("m_valid", 32'(bus.m_valid), 32'(expValid));
          if (expValid) begin
            item = sb.pop_front();
            check("m_texel", bus.m_texel, item.texel);
            check("m_tag", 32'(bus.m_tag), 32'(item.tag));
            lastExpTexel = item.texel;
            lastExpTag   = item.tag;
          end
          lastExpValid = expValid;
        end else begin
          check("hold m_valid", 32'(bus.m_valid), 32'(lastExpValid));
          if (lastExpValid) begin
            check("hold m_texel", bus.m_texel, lastExpTexel);
            check("hold m_tag", 32'(bus.m_tag), 32'(lastExpTag));
          end
        end
      end
    end
  end

  initial begin
    logic        filt;
    logic [7:0]  fs, ft;
    logic [31:0] t00, t01, t10, t11;
    errors       = 0;
    checks       = 0;
    ceEdges      = 0;
    lastExpValid = 1'b0;
    lastExpTexel = '0;
    lastExpTag   = '0;
    resetn       = 1'b1;
    ce           = 1'b0;
    bus.s_valid          = 1'b0;
    bus.confEnableFilter = 1'b1;
    bus.s_tag            = '0;
    bus.texel00          = '0;
    bus.texel01          = '0;
    bus.texel10          = '0;
    bus.texel11          = '0;
    bus.fracS            = '0;
    bus.fracT            = '0;

    #1 resetn = 1'b0;
    #2;
    check("reset m_valid", 32'(bus.m_valid), 32'h0);
    check("reset m_texel", bus.m_texel, 32'h0);
    check("reset m_tag", 32'(bus.m_tag), 32'h0);
    repeat (2) @(negedge aclk);
    resetn = 1'b1;

    // Bilinear: zero fractions return texel00 exactly
    sendBeat(1'b1, 16'hA001, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00,
             8'h00, 8'h00, 32'h11223344);
    // Bilinear: half-way over 0/255 floors to 127 per channel
    sendBeat(1'b1, 16'hA002, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF,
             8'h80, 8'h80, 32'h7F7F7F7F);
    // Nearest selections
    sendBeat(1'b0, 16'hA003, 32'h0A0A0A0A, 32'h1B1B1B1B, 32'h2C2C2C2C, 32'h3D3D3D3D,
             8'hC0, 8'h40, 32'h1B1B1B1B);
    sendBeat(1'b0, 16'hA004, 32'h0A0A0A0A, 32'h1B1B1B1B, 32'h2C2C2C2C, 32'h3D3D3D3D,
             8'h40, 8'hC0, 32'h2C2C2C2C);
    // Mode toggled beat-by-beat
    sendBeat(1'b1, 16'hA005, 32'h10203040, 32'h50607080, 32'hFFFFFFFF, 32'hFFFFFFFF,
             8'h40, 8'h00, 32'h20304050);
    sendBeat(1'b0, 16'hA006, 32'h10203040, 32'h50607080, 32'hFFFFFFFF, 32'hFFFFFFFF,
             8'h40, 8'h00, 32'h10203040);
    sendBeat(1'b1, 16'hA007, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
             8'h00, 8'hFF, 32'hFEFEFEFE);
    sendBeat(1'b0, 16'hA008, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10,
             8'hFF, 8'hFF, 32'h0D0E0F10);
    sendBeat(1'b0, 16'hA009, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10,
             8'h7F, 8'h80, 32'h090A0B0C);

    // Bubble pattern 1,0,1,1,0
    sendBeat(1'b0, 16'hB001, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
             8'h00, 8'h00, 32'h11111111);
    idle(1);
    sendBeat(1'b0, 16'hB002, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
             8'h80, 8'h00, 32'h22222222);
    sendBeat(1'b0, 16'hB003, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
             8'h80, 8'h80, 32'h44444444);
    idle(1);

    // Stall while a beat sits on the output
    sendBeat(1'b1, 16'hB004, 32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080,
             8'h33, 8'h99, 32'h80808080);
    idle(2);
    stall(3);

    // Back-to-back random stream with random stalls
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) stall($urandom_range(1, 3));
      filt = 1'($urandom_range(0, 1));
      fs   = 8'($urandom);
      ft   = 8'($urandom);
      t00  = $urandom;
      t01  = $urandom;
      t10  = $urandom;
      t11  = $urandom;
      sendBeat(filt, 16'hC000 + 16'(i), t00, t01, t10, t11, fs, ft,
               refFilter(filt, t00, t01, t10, t11, fs, ft));
    end
    idle(5);

    // Asynchronous reset with three beats in the pipe
    sendBeat(1'b0, 16'hD001, 32'hAAAAAAAA, 32'h0, 32'h0, 32'h0, 8'h00, 8'h00, 32'hAAAAAAAA);
    sendBeat(1'b0, 16'hD002, 32'hBBBBBBBB, 32'h0, 32'h0, 32'h0, 8'h00, 8'h00, 32'hBBBBBBBB);
    sendBeat(1'b0, 16'hD003, 32'hCCCCCCCC, 32'h0, 32'h0, 32'h0, 8'h00, 8'h00, 32'hCCCCCCCC);
    @(posedge aclk);
    #3;
    resetn = 1'b0;
    #1;
    check("async reset m_valid", 32'(bus.m_valid), 32'h0);
    check("async reset m_texel", bus.m_texel, 32'h0);
    check("async reset m_tag", 32'(bus.m_tag), 32'h0);
    bus.s_valid  = 1'b0;
    sb.delete();
    lastExpValid = 1'b0;
    repeat (2) @(negedge aclk);
    resetn = 1'b1;
    idle(5);
    sendBeat(1'b1, 16'hE001, 32'h11223344, 32'h0, 32'h0, 32'h0, 8'h00, 8'h00, 32'h11223344);
    idle(6);
    check("scoreboard drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
